vga_color_pipe: RTL and testbench
=================================

Name: vga_color_pipe

Overview:
- Parametrised VGA pixel output stage between the game-logic colour source and the DAC/pin outputs, on the 25 MHz VGA clock.
- Re-times the incoming colour through a configurable synchroniser depth and delays x/y by the same amount, so blanking decisions line up with the colour they gate.
- Adds frame-synchronous display modes (pass-through, solid fill, colour bars, bordered pass-through), a frame-start pulse and a frame counter.

Parameters:
- COLOR_W, 3, colour width in bits (rgb_in, bg_color, color).
- SYNC_DEPTH, 2, number of rgb_in sync stages; legal range 1..8.
- CNT_W, 10, width of x_val/y_val.
- X_MAX, 639, last visible column.
- Y_MAX, 479, last visible row.
- BAR_SHIFT, 6, colour-bar width is 2^BAR_SHIFT pixels.
- FRAME_W, 8, frame counter width.

Ports:
- clk  in  1  VGA pixel clock.
- rst_n  in  1  synchronous active-low reset.
- rgb_in  in  COLOR_W  colour from game logic.
- x_val  in  CNT_W  current VGA column counter.
- y_val  in  CNT_W  current VGA row counter.
- mode_in  in  2  requested mode: 0 PASS, 1 SOLID, 2 BARS, 3 BORDER.
- mode_we  in  1  write strobe for mode_in/bg_in.
- bg_in  in  COLOR_W  fill/border colour, written with mode_in.
- color  out  COLOR_W  registered display colour.
- active  out  1  high when color belongs to the visible area.
- frame_start  out  1  one-cycle pulse coincident with color for pixel (0,0).
- frame_cnt  out  FRAME_W  completed-frame counter.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). Reset is sampled only on the rising edge of clk.
- Reset values:
  - All sync stages, delayed x/y and the valid shift register are 0.
  - color=0, active=0, frame_start=0, frame_cnt=0.
  - Active mode=PASS, active bg=0, pending mode=PASS, pending bg=0.
- Pipeline:
  - rgb_in, x_val and y_val each pass through SYNC_DEPTH register stages.
  - A 1-bit valid shift register of the same depth shifts in 1 every cycle after reset.
  - Output register adds one more stage. Total latency is SYNC_DEPTH+1 cycles from input to color/active/frame_start.
- Delayed-stage signals (rgb_d, x_d, y_d, valid_d):
  - vis = valid_d and x_d <= X_MAX and y_d <= Y_MAX.
  - fs = valid_d and x_d==0 and y_d==0.
- Mode shadowing:
  - mode_we=1 loads pending mode and bg on that edge.
  - On a cycle with fs=1, active mode/bg load from the pending registers as they stood before that edge. The new mode applies to pixel (0,0) onward.
  - mode_we asserted in the same cycle as fs: the write lands in pending only, and the old pending value commits. The new value commits at the next frame.
  - Mode never changes mid-frame.
- Colour selection when vis=1 (uses the mode in effect for the pixel, including the commit at fs):
  - PASS: rgb_d.
  - SOLID: bg.
  - BARS: bits [COLOR_W-1:0] of (x_d >> BAR_SHIFT). Wraps modulo 2^COLOR_W.
  - BORDER: bg if x_d==0, x_d==X_MAX, y_d==0 or y_d==Y_MAX; else rgb_d.
- When vis=0: color=0, active=0 in every mode.
- Output flags:
  - active <= vis.
  - frame_start <= fs.
  - frame_cnt increments by 1 on each fs and wraps from 2^FRAME_W-1 to 0.
- No false frame_start after reset: the valid chain masks the zero-filled x/y stages during the first SYNC_DEPTH cycles.
- Reset mid-frame: the pipeline flushes and outputs hold reset values while rst_n=0. The first frame_start occurs at the next real (0,0) input, no earlier than SYNC_DEPTH+1 cycles after release.
- Coordinates beyond X_MAX/Y_MAX (porch/sync regions) are blanked regardless of rgb_in.

Test Plan:
- Latency: defaults, PASS, rgb_in=3'b101 at (10,10) for one cycle, else 0 → color=3'b101 exactly 3 cycles later for one cycle, active=1 that cycle.
- Blanking: rgb_in=3'b111 constant, x sweeps 630..660 at y=5 → color=3'b111 for x_d<=639, color=0 and active=0 for x_d>=640. Repeat with y=480 → all 0.
- Shadow commit: mode_we with mode_in=SOLID, bg_in=3'b010 mid-frame at (100,200) → output unchanged (PASS) until (0,0); from frame_start cycle onward color=3'b010 on visible pixels. Write coincident with fs → applies one frame later.
- Bars: BARS mode, row y=0 → color=0 for x 0..63, 1 for x 64..127, …, 7 for x 448..511, wraps to 0 for x 512..575, 1 for x 576..639.
- Border: BORDER, bg=3'b100, rgb_in=3'b001 → 3'b100 at x=0, x=639, y=0, y=479; 3'b001 at (1,1) and (638,478).
- Reset/frame count: run 3 full 800x525 frames → frame_cnt=3, three frame_start pulses. Assert rst_n=0 at (300,100) for 2 cycles → all outputs 0, frame_cnt=0, no frame_start until the next (0,0).
- Parametrisation: rerun the latency test with SYNC_DEPTH=4, COLOR_W=12 → latency 5 cycles, 12-bit values pass unaltered.

Source files
------------

// File: rtl/vga_color_pipe.sv
// VGA pixel output stage: re-times colour and coordinates, applies frame-synchronous
// display modes, and produces the frame-start pulse and frame counter.
module vga_color_pipe #(
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned SYNC_DEPTH = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479,
  parameter int unsigned BAR_SHIFT  = 6,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] rgb_in,
  input  logic [CNT_W-1:0]   x_val,
  input  logic [CNT_W-1:0]   y_val,
  input  logic [1:0]         mode_in,
  input  logic               mode_we,
  input  logic [COLOR_W-1:0] bg_in,
  output logic [COLOR_W-1:0] color,
  output logic               active,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_SOLID  = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_BORDER = 2'd3
  } mode_e;

  logic [COLOR_W-1:0]    r_rgb_sr [SYNC_DEPTH];
  logic [CNT_W-1:0]      r_x_sr   [SYNC_DEPTH];
  logic [CNT_W-1:0]      r_y_sr   [SYNC_DEPTH];
  logic [SYNC_DEPTH-1:0] r_valid_sr;

  mode_e              r_mode;
  mode_e              r_pend_mode;
  logic [COLOR_W-1:0] r_bg;
  logic [COLOR_W-1:0] r_pend_bg;

  logic [COLOR_W-1:0] w_rgb_d;
  logic [CNT_W-1:0]   w_x_d;
  logic [CNT_W-1:0]   w_y_d;
  logic               w_valid_d;
  logic               w_vis;
  logic               w_fs;
  logic               w_edge;
  mode_e              w_mode_eff;
  logic [COLOR_W-1:0] w_bg_eff;
  logic [COLOR_W-1:0] w_color;

  assign w_rgb_d   = r_rgb_sr[SYNC_DEPTH-1];
  assign w_x_d     = r_x_sr[SYNC_DEPTH-1];
  assign w_y_d     = r_y_sr[SYNC_DEPTH-1];
  assign w_valid_d = r_valid_sr[SYNC_DEPTH-1];

  // Synchroniser chain; the valid bits mask the zero-filled stages after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        r_rgb_sr[i] <= '0;
        r_x_sr[i]   <= '0;
        r_y_sr[i]   <= '0;
      end
      r_valid_sr <= '0;
    end else begin
      r_rgb_sr[0]   <= rgb_in;
      r_x_sr[0]     <= x_val;
      r_y_sr[0]     <= y_val;
      r_valid_sr[0] <= 1'b1;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_rgb_sr[i]   <= r_rgb_sr[i-1];
        r_x_sr[i]     <= r_x_sr[i-1];
        r_y_sr[i]     <= r_y_sr[i-1];
        r_valid_sr[i] <= r_valid_sr[i-1];
      end
    end
  end

  // Visibility, frame start and colour selection at the delayed stage
  always_comb begin
    w_vis      = 1'b0;
    w_fs       = 1'b0;
    w_edge     = 1'b0;
    w_mode_eff = r_mode;
    w_bg_eff   = r_bg;
    w_color    = '0;

    w_vis  = w_valid_d && (w_x_d <= CNT_W'(X_MAX)) && (w_y_d <= CNT_W'(Y_MAX));
    w_fs   = w_valid_d && (w_x_d == '0) && (w_y_d == '0);
    w_edge = (w_x_d == '0) || (w_x_d == CNT_W'(X_MAX)) ||
             (w_y_d == '0) || (w_y_d == CNT_W'(Y_MAX));

    // The committing pixel (0,0) already uses the pending mode
    if (w_fs) begin
      w_mode_eff = r_pend_mode;
      w_bg_eff   = r_pend_bg;
    end

    if (w_vis) begin
      case (w_mode_eff)
        MODE_PASS:   w_color = w_rgb_d;
        MODE_SOLID:  w_color = w_bg_eff;
        MODE_BARS:   w_color = COLOR_W'(w_x_d >> BAR_SHIFT);
        MODE_BORDER: w_color = w_edge ? w_bg_eff : w_rgb_d;
        default:     w_color = '0;
      endcase
    end
  end

  // Mode shadow registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode      <= MODE_PASS;
      r_pend_mode <= MODE_PASS;
      r_bg        <= '0;
      r_pend_bg   <= '0;
      color       <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (mode_we) begin
        r_pend_mode <= mode_e'(mode_in);
        r_pend_bg   <= bg_in;
      end
      if (w_fs) begin
        r_mode    <= r_pend_mode;
        r_bg      <= r_pend_bg;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
      color       <= w_color;
      active      <= w_vis;
      frame_start <= w_fs;
    end
  end

endmodule

// File: tb/tb_vga_color_pipe.sv
// Directed bench for vga_color_pipe: default build plus a SYNC_DEPTH=4 / 12-bit build.
module tb_vga_color_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rgb_in;
  logic [9:0]  x_val;
  logic [9:0]  y_val;
  logic [1:0]  mode_in;
  logic        mode_we;
  logic [2:0]  bg_in;
  logic [2:0]  color;
  logic        active;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  logic [11:0] rgb2;
  logic [11:0] bg2;
  logic [11:0] color2;
  logic        active2;
  logic        fs2;
  logic [7:0]  fcnt2;

  int n_total = 0;
  int n_bad   = 0;

  logic [4:0] q_exp[$];
  string      q_tag[$];

  assign bg2 = 12'(bg_in);

  always #20 clk = ~clk;

  vga_color_pipe dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .x_val(x_val), .y_val(y_val),
    .mode_in(mode_in), .mode_we(mode_we), .bg_in(bg_in),
    .color(color), .active(active), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_color_pipe #(.COLOR_W(12), .SYNC_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb2), .x_val(x_val), .y_val(y_val),
    .mode_in(mode_in), .mode_we(mode_we), .bg_in(bg2),
    .color(color2), .active(active2), .frame_start(fs2), .frame_cnt(fcnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel and queue its expected output; the default build shows it 3 edges later
  task automatic pix(input int x, input int y, input logic [2:0] rgb,
                     input logic [2:0] ec, input logic ea, input logic ef, input string tag);
    logic [4:0] e;
    string      t;
    x_val  = 10'(x);
    y_val  = 10'(y);
    rgb_in = rgb;
    q_exp.push_back({ec, ea, ef});
    q_tag.push_back($sformatf("%s(%0d,%0d)", tag, x, y));
    step();
    if (q_exp.size() >= 3) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      chk({t, ".color"},       32'(color),       32'(e[4:2]));
      chk({t, ".active"},      32'(active),      32'(e[1]));
      chk({t, ".frame_start"}, 32'(frame_start), 32'(e[0]));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) pix(700, 500, 3'd0, 3'd0, 1'b0, 1'b0, "drain");
  endtask

  // Leave reset: the two register stages ahead of the output still hold flushed zeros
  task automatic release_reset();
    rst_n = 1'b1;
    q_exp.delete();
    q_tag.delete();
    q_exp.push_back(5'd0); q_tag.push_back("flush0");
    q_exp.push_back(5'd0); q_tag.push_back("flush1");
  endtask

  initial begin
    rst_n   = 1'b0;
    mode_we = 1'b0;
    mode_in = 2'd0;
    bg_in   = 3'd0;
    rgb_in  = 3'd7;
    rgb2    = 12'hFFF;
    x_val   = '0;
    y_val   = '0;
    repeat (3) step();
    chk("rst.color",       32'(color),       32'd0);
    chk("rst.active",      32'(active),      32'd0);
    chk("rst.frame_start", 32'(frame_start), 32'd0);
    chk("rst.frame_cnt",   32'(frame_cnt),   32'd0);
    chk("rst.color2",      32'(color2),      32'd0);
    chk("rst.fs2",         32'(fs2),         32'd0);

    // No spurious frame_start while the zero-filled stages drain out
    rgb2 = 12'd0;
    release_reset();
    for (int i = 0; i < 5; i++) begin
      pix(700, 500, 3'd7, 3'd0, 1'b0, 1'b0, "boot");
      chk("boot.fs2", 32'(fs2), 32'd0);
    end

    // Latency: single coloured pixel; wide build has 5-cycle latency
    pix(0, 0, 3'd0, 3'd0, 1'b1, 1'b1, "lat.origin");
    pix(5, 10, 3'd0, 3'd0, 1'b1, 1'b0, "lat.pre");
    rgb2 = 12'hA5C;
    pix(10, 10, 3'b101, 3'b101, 1'b1, 1'b0, "lat.hit");
    rgb2 = 12'd0;
    for (int i = 1; i <= 5; i++) begin
      pix(11, 10, 3'd0, 3'd0, 1'b1, 1'b0, "lat.post");
      if (i == 3) chk("lat2.before", 32'(color2), 32'h0);
      if (i == 4) begin
        chk("lat2.hit",    32'(color2),  32'hA5C);
        chk("lat2.active", 32'(active2), 32'd1);
      end
      if (i == 5) chk("lat2.after", 32'(color2), 32'h0);
    end

    // Blanking across the right edge, then on a non-visible row
    for (int x = 630; x <= 660; x++)
      pix(x, 5, 3'd7, (x <= 639) ? 3'd7 : 3'd0, (x <= 639), 1'b0, "blank.y5");
    for (int x = 630; x <= 660; x++)
      pix(x, 480, 3'd7, 3'd0, 1'b0, 1'b0, "blank.y480");
    drain(2);
    chk("cnt.after_lat", 32'(frame_cnt), 32'd1);

    // Shadowed mode write mid-frame takes effect at the next (0,0)
    mode_we = 1'b1; mode_in = 2'd1; bg_in = 3'b010;
    pix(100, 200, 3'd3, 3'd3, 1'b1, 1'b0, "shadow.write");
    mode_we = 1'b0;
    pix(101, 200, 3'd3, 3'd3, 1'b1, 1'b0, "shadow.hold");
    pix(700, 500, 3'd3, 3'd0, 1'b0, 1'b0, "shadow.porch");
    pix(0, 0, 3'd3, 3'b010, 1'b1, 1'b1, "shadow.commit");
    pix(1, 1, 3'd3, 3'b010, 1'b1, 1'b0, "shadow.solid");
    // This write coincides with the (0,0) commit edge, so it waits a frame
    mode_we = 1'b1; mode_in = 2'd0; bg_in = 3'd0;
    pix(2, 1, 3'd3, 3'b010, 1'b1, 1'b0, "shadow.fswrite");
    mode_we = 1'b0;
    pix(3, 1, 3'd3, 3'b010, 1'b1, 1'b0, "shadow.still");
    pix(700, 500, 3'd3, 3'd0, 1'b0, 1'b0, "shadow.porch2");
    pix(0, 0, 3'd3, 3'd3, 1'b1, 1'b1, "shadow.pass");
    pix(4, 4, 3'd3, 3'd3, 1'b1, 1'b0, "shadow.pass2");

    // Colour bars along row 0, wrapping every 8 bars
    mode_we = 1'b1; mode_in = 2'd2; bg_in = 3'd0;
    pix(700, 500, 3'd5, 3'd0, 1'b0, 1'b0, "bars.write");
    mode_we = 1'b0;
    pix(0, 0, 3'd5, 3'd0, 1'b1, 1'b1, "bars.origin");
    pix(63, 0, 3'd5, 3'd0, 1'b1, 1'b0, "bars");
    for (int k = 1; k <= 9; k++) begin
      pix(64 * k,      0, 3'd5, 3'(k % 8), 1'b1, 1'b0, "bars");
      pix(64 * k + 63, 0, 3'd5, 3'(k % 8), 1'b1, 1'b0, "bars");
    end
    pix(640, 0, 3'd5, 3'd0, 1'b0, 1'b0, "bars.blank");

    // Border around the visible area
    mode_we = 1'b1; mode_in = 2'd3; bg_in = 3'b100;
    pix(700, 500, 3'd1, 3'd0, 1'b0, 1'b0, "border.write");
    mode_we = 1'b0;
    pix(0, 0,     3'd1, 3'b100, 1'b1, 1'b1, "border");
    pix(639, 10,  3'd1, 3'b100, 1'b1, 1'b0, "border");
    pix(10, 0,    3'd1, 3'b100, 1'b1, 1'b0, "border");
    pix(10, 479,  3'd1, 3'b100, 1'b1, 1'b0, "border");
    pix(1, 1,     3'd1, 3'b001, 1'b1, 1'b0, "border.in");
    pix(638, 478, 3'd1, 3'b001, 1'b1, 1'b0, "border.in");
    pix(639, 479, 3'd1, 3'b100, 1'b1, 1'b0, "border");
    pix(640, 479, 3'd1, 3'd0,   1'b0, 1'b0, "border.blank");
    pix(300, 100, 3'd1, 3'b001, 1'b1, 1'b0, "border.in");
    drain(2);
    chk("cnt.before_rst", 32'(frame_cnt), 32'd5);

    // Reset mid-frame for two cycles
    x_val = 10'd300; y_val = 10'd100; rgb_in = 3'd1;
    rst_n = 1'b0;
    repeat (2) step();
    chk("midrst.color",       32'(color),       32'd0);
    chk("midrst.active",      32'(active),      32'd0);
    chk("midrst.frame_start", 32'(frame_start), 32'd0);
    chk("midrst.frame_cnt",   32'(frame_cnt),   32'd0);
    release_reset();
    pix(301, 100, 3'd1, 3'd1, 1'b1, 1'b0, "post.pass");
    pix(700, 500, 3'd1, 3'd0, 1'b0, 1'b0, "post.porch");
    for (int f = 0; f < 3; f++) begin
      pix(0, 0,     3'd1, 3'd1, 1'b1, 1'b1, "frame.origin");
      pix(5, 5,     3'd1, 3'd1, 1'b1, 1'b0, "frame.px");
      pix(700, 500, 3'd1, 3'd0, 1'b0, 1'b0, "frame.porch");
    end
    drain(4);
    chk("cnt.three",  32'(frame_cnt), 32'd3);
    chk("cnt2.three", 32'(fcnt2),     32'd3);

    // Frame counter wrap
    for (int f = 0; f < 252; f++) begin
      pix(0, 0,     3'd0, 3'd0, 1'b1, 1'b1, "wrap.origin");
      pix(700, 500, 3'd0, 3'd0, 1'b0, 1'b0, "wrap.porch");
    end
    drain(4);
    chk("cnt.255",  32'(frame_cnt), 32'd255);
    chk("cnt2.255", 32'(fcnt2),     32'd255);
    pix(0, 0, 3'd0, 3'd0, 1'b1, 1'b1, "wrap.last");
    drain(4);
    chk("cnt.wrap",  32'(frame_cnt), 32'd0);
    chk("cnt2.wrap", 32'(fcnt2),     32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
